// File: rtl/uart_hex_sample_loader.sv
// Parses ASCII hex lines from a UART byte stream into fixed-width samples queued in a FWFT FIFO.
// Define UART_HEX_LOADER_ERRCNT_EN to build the saturating malformed-line counter on err_count.
module uart_hex_sample_loader #(
  parameter int SAMPLE_BITLEN = 24,
  parameter int FIFO_DEPTH    = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rvalid,
  output logic                          rready,
  input  logic [7:0]                    rdata,
  output logic [SAMPLE_BITLEN-1:0]      sample_out,
  output logic                          sample_valid,
  input  logic                          sample_ready,
  output logic                          line_err,
  output logic [15:0]                   err_count,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int ND = SAMPLE_BITLEN / 4;
  localparam int CW = $clog2(ND + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {IDLE, DIGITS, WAIT_EOL, DISCARD} state_t;

  state_t                   state;
  logic [CW-1:0]            digit_cnt;
  logic [SAMPLE_BITLEN-1:0] shreg;
  logic [SAMPLE_BITLEN-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]            wptr;
  logic [AW-1:0]            rptr;
  logic [LW-1:0]            level;
  logic                     accept;
  logic                     is_eol;
  logic                     is_hex;
  logic                     push;
  logic                     pop;
  logic                     fifo_full;
  logic [3:0]               nibble;

  // Letters map via their low ASCII nibble: 'A'/'a' end in 1, plus 9 gives 10.
  always_comb begin
    is_eol = (rdata == 8'h0D) || (rdata == 8'h0A);
    is_hex = 1'b0;
    nibble = 4'h0;
    if (rdata >= 8'h30 && rdata <= 8'h39) begin
      is_hex = 1'b1;
      nibble = rdata[3:0];
    end else if ((rdata >= 8'h41 && rdata <= 8'h46) || (rdata >= 8'h61 && rdata <= 8'h66)) begin
      is_hex = 1'b1;
      nibble = rdata[3:0] + 4'd9;
    end
  end

  // Only a completed line waiting on a full FIFO applies backpressure.
  assign fifo_full    = (level == LW'(FIFO_DEPTH));
  assign rready       = !((state == WAIT_EOL) && fifo_full);
  assign accept       = rvalid && rready;
  assign push         = accept && (state == WAIT_EOL) && is_eol;
  assign sample_valid = (level != '0);
  assign pop          = sample_valid && sample_ready;
  assign sample_out   = mem[rptr];
  assign fifo_level   = level;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      digit_cnt <= '0;
      shreg     <= '0;
      line_err  <= 1'b0;
    end else begin
      line_err <= 1'b0;
      if (accept) begin
        case (state)
          IDLE: begin
            if (is_hex) begin
              shreg     <= SAMPLE_BITLEN'(nibble);
              digit_cnt <= CW'(1);
              state     <= (ND == 1) ? WAIT_EOL : DIGITS;
            end else if (!is_eol) begin
              line_err <= 1'b1;
              state    <= DISCARD;
            end
          end
          DIGITS: begin
            if (is_hex) begin
              shreg     <= (shreg << 4) | SAMPLE_BITLEN'(nibble);
              digit_cnt <= digit_cnt + CW'(1);
              if (digit_cnt == CW'(ND - 1))
                state <= WAIT_EOL;
            end else begin
              line_err  <= 1'b1;
              digit_cnt <= '0;
              state     <= is_eol ? IDLE : DISCARD;
            end
          end
          WAIT_EOL: begin
            digit_cnt <= '0;
            if (is_eol) begin
              state <= IDLE;
            end else begin
              line_err <= 1'b1;
              state    <= DISCARD;
            end
          end
          DISCARD: begin
            if (is_eol)
              state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Storage is left unreset; level alone decides whether the head is meaningful.
  always_ff @(posedge clk) begin
    if (push)
      mem[wptr] <= shreg;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (push)
        wptr <= wptr + AW'(1);
      if (pop)
        rptr <= rptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

`ifdef UART_HEX_LOADER_ERRCNT_EN
  logic [15:0] err_cnt_q;

  always_ff @(posedge clk) begin
    if (rst)
      err_cnt_q <= 16'h0000;
    else if (line_err && err_cnt_q != 16'hFFFF)
      err_cnt_q <= err_cnt_q + 16'd1;
  end

  assign err_count = err_cnt_q;
`else
  assign err_count = 16'h0000;
`endif

endmodule
